uart_host_bridge: RTL and testbench

- Single-clock bridge between a host byte-stream (valid/ready) and the parallel side of the team's UART core (ld_tx_data/tx_empty, uld_rx_data/rx_empty).
- Buffers host TX bytes and feeds them to the UART one at a time.
- Drains received bytes from the UART into an RX buffer for the host.
- The UART core's txclk and rxclk are both tied to this block's clk.

---
 rtl/uart_host_bridge_pkg.sv | 9 +
 rtl/uart_host_bridge_fifo.sv | 48 ++++
 rtl/uart_host_bridge.sv | 143 ++++++++++++++
 tb/tb_uart_host_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_bridge_pkg.sv
// Shared types for the UART host bridge: FSM state encodings and the default byte width.
package uart_host_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_HOLD} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_UNLOAD, RX_CAPTURE} rx_state_t;

endpackage

// File: rtl/uart_host_bridge_fifo.sv
// Single-clock show-ahead FIFO used for both bridge directions.
// head_o reads as zero while empty so the host side never sees stale bytes.
module uart_host_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Depth is a power of two, so the pointers wrap naturally; the count tells full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Bridges a host valid/ready byte stream to the UART core's load/unload parallel interface.
// Define UART_HOST_BRIDGE_STATUS_EN to add the tx_sent_cnt/rx_recv_cnt counters and clr_cnt.
module uart_host_bridge
  import uart_host_bridge_pkg::*;
#(
  parameter int DATA_W   = BYTE_W,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_byte,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_byte,
  output logic              ld_tx_data,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_empty,
  output logic              uld_rx_data,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_empty
`ifdef UART_HOST_BRIDGE_STATUS_EN
  ,
  output logic [15:0]       tx_sent_cnt,
  output logic [15:0]       rx_recv_cnt,
  input  logic              clr_cnt
`endif
);

  tx_state_t         tx_state_q, tx_state_d;
  rx_state_t         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] tx_head;
  logic              tx_full, tx_fifo_empty, tx_push, tx_pop;
  logic              rx_full, rx_fifo_empty, rx_push, rx_pop;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = !rx_fifo_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign tx_data  = tx_data_q;

  uart_host_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tx_push),
    .data_i  (tx_byte),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_fifo_empty)
  );

  uart_host_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rx_push),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .head_o  (rx_byte),
    .full_o  (rx_full),
    .empty_o (rx_fifo_empty)
  );

  // tx_data is captured on entry to LOAD so it stays stable through the pulse and afterwards.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    ld_tx_data = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_fifo_empty && tx_empty) begin
          tx_state_d = TX_LOAD;
          tx_data_d  = tx_head;
        end
      end
      TX_LOAD: begin
        ld_tx_data = 1'b1;
        tx_pop     = 1'b1;
        tx_state_d = TX_HOLD;
      end
      TX_HOLD: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    uld_rx_data = 1'b0;
    rx_push     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_empty && !rx_full) rx_state_d = RX_UNLOAD;
      end
      RX_UNLOAD: begin
        uld_rx_data = 1'b1;
        rx_state_d  = RX_CAPTURE;
      end
      RX_CAPTURE: begin
        rx_push    = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef UART_HOST_BRIDGE_STATUS_EN
  logic [15:0] tx_sent_cnt_q, rx_recv_cnt_q;

  // A clear wins over an increment landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sent_cnt_q <= '0;
      rx_recv_cnt_q <= '0;
    end else if (clr_cnt) begin
      tx_sent_cnt_q <= '0;
      rx_recv_cnt_q <= '0;
    end else begin
      if (ld_tx_data) tx_sent_cnt_q <= tx_sent_cnt_q + 16'd1;
      if (rx_push)    rx_recv_cnt_q <= rx_recv_cnt_q + 16'd1;
    end
  end

  assign tx_sent_cnt = tx_sent_cnt_q;
  assign rx_recv_cnt = rx_recv_cnt_q;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: directed scenarios plus a randomized run
// checked every cycle against a queue-based model of the bridge's handshake rules.
module tb_uart_host_bridge;

  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_byte, rx_byte, tx_data, rx_data;
  logic       ld_tx_data, uld_rx_data, tx_empty, rx_empty;
`ifdef UART_HOST_BRIDGE_STATUS_EN
  logic [15:0] tx_sent_cnt, rx_recv_cnt;
  logic        clr_cnt;
`endif

  int tests, fails;

  // UART-side stimulus state
  logic       txEmptyR;
  int         txBusy, txFrame;
  bit         txHold;
  logic [7:0] rxSrc [512];
  int         rxSrcCnt, rxIdx;

  // Observation logs
  logic [7:0] ldBytes[$], popBytes[$];
  int         ldCycles[$];
  int         uldCount, cyc;

  // Reference model state
  logic [7:0] mTxQ[$], mRxQ[$];
  logic [7:0] mTxData;
  bit         expLd, expLdD1, expUld, expUldD1;
  int         mRxIdx;

  int n0, u0, p0;
  bit seen, accepted;

  uart_host_bridge #(.DATA_W(8), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_byte     (tx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_byte     (rx_byte),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_empty    (tx_empty),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty)
`ifdef UART_HOST_BRIDGE_STATUS_EN
    ,
    .tx_sent_cnt (tx_sent_cnt),
    .rx_recv_cnt (rx_recv_cnt),
    .clr_cnt     (clr_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign tx_empty = txEmptyR && !txHold;
  assign rx_empty = (rxIdx >= rxSrcCnt);

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of host inputs; call at posedge+1, returns at the next posedge+1.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
    tx_valid = v;
    tx_byte  = b;
    rx_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_tx_ready", 16'(tx_ready), 16'd1);
    checkOutput("rst_rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("rst_rx_byte", 16'(rx_byte), 16'd0);
    checkOutput("rst_ld_tx_data", 16'(ld_tx_data), 16'd0);
    checkOutput("rst_tx_data", 16'(tx_data), 16'd0);
    checkOutput("rst_uld_rx_data", 16'(uld_rx_data), 16'd0);
  endtask

  // UART core model: TX holding register busy for txFrame cycles after a load;
  // RX side hands out rxSrc bytes in order, rx_data valid the cycle after an unload.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txEmptyR <= 1'b1;
      txBusy   <= 0;
      rxIdx    <= rxSrcCnt;
      rx_data  <= '0;
    end else begin
      if (ld_tx_data) begin
        txEmptyR <= 1'b0;
        txBusy   <= txFrame;
      end else if (txBusy > 1) begin
        txBusy <= txBusy - 1;
      end else if (txBusy == 1) begin
        txBusy   <= 0;
        txEmptyR <= 1'b1;
      end
      if (uld_rx_data && rxIdx < rxSrcCnt) begin
        rx_data <= rxSrc[rxIdx];
        rxIdx   <= rxIdx + 1;
      end
    end
  end

  // Observation log of what the DUT actually did, used by the directed checks.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      if (ld_tx_data) begin
        ldBytes.push_back(tx_data);
        ldCycles.push_back(cyc);
      end
      if (uld_rx_data) uldCount++;
      if (rx_valid && rx_ready) popBytes.push_back(rx_byte);
    end
  end

  // Reference model: queues hold buffered bytes; a load/unload happens the cycle after its
  // condition held, and each direction moves at most one byte per 3 cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mTxQ.delete();
      mRxQ.delete();
      mTxData  = '0;
      expLd    = 1'b0;
      expLdD1  = 1'b0;
      expUld   = 1'b0;
      expUldD1 = 1'b0;
      mRxIdx   = rxSrcCnt;
    end else begin
      bit nextLd, nextUld, txPush, rxPop, capture;
      txPush  = tx_valid && (mTxQ.size() < TX_DEPTH);
      nextLd  = (mTxQ.size() > 0) && tx_empty && !expLd && !expLdD1;
      capture = expUldD1;
      rxPop   = (mRxQ.size() > 0) && rx_ready;
      nextUld = !rx_empty && (mRxQ.size() < RX_DEPTH) && !expUld && !expUldD1;
      if (expLd) mTxData = mTxQ.pop_front();
      if (txPush) mTxQ.push_back(tx_byte);
      if (rxPop) void'(mRxQ.pop_front());
      if (capture) begin
        mRxQ.push_back(rxSrc[mRxIdx]);
        mRxIdx++;
      end
      expLdD1  = expLd;
      expLd    = nextLd;
      expUldD1 = expUld;
      expUld   = nextUld;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("tx_ready", 16'(tx_ready), 16'(mTxQ.size() < TX_DEPTH));
      checkOutput("ld_tx_data", 16'(ld_tx_data), 16'(expLd));
      checkOutput("tx_data", 16'(tx_data), 16'(expLd ? mTxQ[0] : mTxData));
      checkOutput("uld_rx_data", 16'(uld_rx_data), 16'(expUld));
      checkOutput("rx_valid", 16'(rx_valid), 16'(mRxQ.size() > 0));
      if (mRxQ.size() > 0) checkOutput("rx_byte", 16'(rx_byte), 16'(mRxQ[0]));
    end
  end

  initial begin
    tests = 0; fails = 0; uldCount = 0; cyc = 0;
    reset_n = 1'b0; tx_valid = 1'b0; tx_byte = '0; rx_ready = 1'b0;
    txHold = 1'b0; txFrame = 6; rxSrcCnt = 0;
`ifdef UART_HOST_BRIDGE_STATUS_EN
    clr_cnt = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    reset_n = 1'b1;

    // Idle: nothing queued on either side
    n0 = ldBytes.size(); u0 = uldCount;
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_tx_ready", 16'(tx_ready), 16'd1);
    checkOutput("idle_rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("idle_ld_count", 16'(ldBytes.size() - n0), 16'd0);
    checkOutput("idle_uld_count", 16'(uldCount - u0), 16'd0);

    // Single push: load two cycles later; next load waits for tx_empty to return
    n0 = ldBytes.size();
    tx_valid = 1'b1; tx_byte = 8'hA5;
    @(posedge clk); #1;
    tx_byte = 8'h5A;
    @(negedge clk);
    checkOutput("ld_one_cycle_after_push", 16'(ld_tx_data), 16'd0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    checkOutput("ld_two_cycles_after_push", 16'(ld_tx_data), 16'd1);
    checkOutput("ld_data_a5", 16'(tx_data), 16'h00A5);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ld_count_two", 16'(ldBytes.size() - n0), 16'd2);
    if (ldBytes.size() >= n0 + 2) begin
      checkOutput("ld_spacing_frame6", 16'(ldCycles[n0+1] - ldCycles[n0]), 16'd8);
      checkOutput("ld_second_byte", 16'(ldBytes[n0+1]), 16'h005A);
    end

    // Fill the TX FIFO while the UART is busy, then release it
    txHold = 1'b1;
    n0 = ldBytes.size();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    tx_valid = 1'b1; tx_byte = 8'h05;
    @(negedge clk);
    checkOutput("tx_ready_full", 16'(tx_ready), 16'd0);
    @(posedge clk); #1;
    repeat (4) applyStimulus(1'b1, 8'h05, 1'b0);
    txHold = 1'b0;
    accepted = 1'b0;
    for (int k = 0; k < 60 && !accepted; k++) begin
      if (tx_ready) accepted = 1'b1;
      applyStimulus(1'b1, 8'h05, 1'b0);
    end
    tx_valid = 1'b0;
    checkOutput("tx_fifth_accepted", 16'(accepted), 16'd1);
    repeat (60) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ld_count_five", 16'(ldBytes.size() - n0), 16'd5);
    for (int j = 0; j < 5; j++)
      if (n0 + j < ldBytes.size()) checkOutput("tx_order", 16'(ldBytes[n0+j]), 16'(j + 1));

    // One received byte
    u0 = uldCount;
    rxSrc[rxSrcCnt] = 8'h3C; rxSrcCnt++;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (uld_rx_data) seen = 1'b1;
    end
    checkOutput("uld_seen", 16'(seen), 16'd1);
    if (seen) begin
      @(negedge clk);
      checkOutput("rx_valid_one_after_uld", 16'(rx_valid), 16'd0);
      @(negedge clk);
      checkOutput("rx_valid_two_after_uld", 16'(rx_valid), 16'd1);
      checkOutput("rx_byte_3c", 16'(rx_byte), 16'h003C);
    end
    @(posedge clk); #1;
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("uld_once", 16'(uldCount - u0), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rx_valid_after_pop", 16'(rx_valid), 16'd0);

    // RX FIFO full backpressure: fifth byte stays in the UART until a pop
    u0 = uldCount; p0 = popBytes.size();
    for (int j = 0; j < 5; j++) rxSrc[rxSrcCnt+j] = 8'(8'h11 * (j + 1));
    rxSrcCnt += 5;
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("uld_count_full", 16'(uldCount - u0), 16'd4);
    checkOutput("rx_valid_full", 16'(rx_valid), 16'd1);
    checkOutput("uart_keeps_fifth", 16'(rx_empty), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("uld_count_after_pop", 16'(uldCount - u0), 16'd5);
    repeat (12) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rx_pop_count", 16'(popBytes.size() - p0), 16'd5);
    for (int j = 0; j < 5; j++)
      if (p0 + j < popBytes.size()) checkOutput("rx_order", 16'(popBytes[p0+j]), 16'(8'h11 * (j + 1)));

    // Reset in the HOLD cycle with three bytes still queued
    txHold = 1'b1; txFrame = 20;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA1 + i), 1'b0);
    tx_valid = 1'b0; txHold = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (ld_tx_data) seen = 1'b1;
    end
    checkOutput("hold_load_seen", 16'(seen), 16'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkResetValues();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    txFrame = 6;
    n0 = ldBytes.size();
    repeat (15) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ld_after_reset", 16'(ldBytes.size() - n0), 16'd0);
    checkOutput("tx_ready_after_reset", 16'(tx_ready), 16'd1);

`ifdef UART_HOST_BRIDGE_STATUS_EN
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    tx_valid = 1'b0;
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("tx_sent_cnt_3", tx_sent_cnt, 16'd3);
    checkOutput("rx_recv_cnt_0", rx_recv_cnt, 16'd0);
    clr_cnt = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    clr_cnt = 1'b0;
    checkOutput("tx_sent_cnt_clr", tx_sent_cnt, 16'd0);
`endif

    // Randomized traffic in both directions with alternating host RX pressure
    for (int k = 0; k < 3000; k++) begin
      txFrame = $urandom_range(1, 8);
      if (rxSrcCnt < 500 && $urandom_range(0, 9) == 0) begin
        rxSrc[rxSrcCnt] = 8'($urandom);
        rxSrcCnt++;
      end
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    ((k / 300) % 2 == 0) ? 1'($urandom_range(0, 7) == 0)
                                         : 1'($urandom_range(0, 3) != 0));
    end
    repeat (200) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rand_rx_drained", 16'(rx_valid), 16'd0);
    checkOutput("rand_tx_drained", 16'(tx_ready), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
